// File: rtl/imm_encode_unit.sv
// Immediate encoder: places a two's-complement immediate into the RISC-V
// instruction bit positions for its type, with a two-stage valid/ready pipeline.
module imm_encode_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  function automatic logic legal_imm(input logic [2:0] t, input logic signed [31:0] imm);
    case (t)
      T_I, T_S: return (&imm[31:11]) | ~(|imm[31:11]);
      T_B:      return ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      T_J:      return ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      T_U:      return ~(|imm[11:0]);
      T_R:      return ~(|imm);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] t);
    case (t)
      T_I:      return 32'hFFF0_0000;
      T_S, T_B: return 32'hFE00_0F80;
      T_U, T_J: return 32'hFFFF_F000;
      default:  return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] place_imm(input logic [2:0] t, input logic signed [31:0] imm);
    logic [31:0] p;
    p = '0;
    case (t)
      T_I: p[31:20] = imm[11:0];
      T_S: begin
        p[31:25] = imm[11:5];
        p[11:7]  = imm[4:0];
      end
      T_B: begin
        p[31]    = imm[12];
        p[30:25] = imm[10:5];
        p[11:8]  = imm[4:1];
        p[7]     = imm[11];
      end
      T_U: p[31:12] = imm[31:12];
      T_J: begin
        p[31]    = imm[20];
        p[30:21] = imm[10:1];
        p[20]    = imm[11];
        p[19:12] = imm[19:12];
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic               rdy_en;
  logic               vld_p1, vld_p2;
  logic [2:0]         type_p1;
  logic signed [31:0] imm_p1;
  logic [31:0]        base_p1;
  logic               ok_p1;
  logic [31:0]        inst_p2;
  logic               err_p2;
  logic               adv_p1, adv_p2, in_fire, out_fire;
  logic [31:0]        enc_inst;

  assign adv_p2   = !vld_p2 | out_ready;
  assign adv_p1   = !vld_p1 | adv_p2;
  assign in_ready = rdy_en & adv_p1;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = vld_p2 & out_ready;

  // in_ready is held low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // S1: capture inputs, decide representability
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= in_fire;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      type_p1 <= in_type;
      imm_p1  <= in_imm;
      base_p1 <= in_base;
      ok_p1   <= legal_imm(in_type, in_imm);
    end
  end

  // Illegal types pass the base word through untouched; otherwise the
  // immediate field is cleared and refilled only when representable.
  always_comb begin
    enc_inst = base_p1;
    if (type_p1 <= T_J)
      enc_inst = (base_p1 & ~imm_mask(type_p1)) | (ok_p1 ? place_imm(type_p1, imm_p1) : 32'h0);
  end

  // S2: encoded word held for the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      inst_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        inst_p2 <= enc_inst;
        err_p2  <= !ok_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (in_fire)           acc_cnt <= sat_inc(acc_cnt);
      if (out_fire & err_p2) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid = vld_p2;
  assign out_inst  = inst_p2;
  assign out_err   = err_p2;

endmodule

// File: tb/tb_imm_encode_unit.sv
// Scoreboard bench for imm_encode_unit: directed vectors with hand-computed
// encodings, random backpressure, mid-stream reset and counter saturation.
module tb_imm_encode_unit;

  localparam int CW  = 4;
  localparam int NV  = 18;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_type = '0;
  logic [31:0]   in_imm = '0;
  logic [31:0]   in_base = '0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] acc_cnt, err_cnt;

  imm_encode_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .acc_cnt(acc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   bp_mode = 0;

  logic [2:0]  vt   [NV] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4, 3'd2, 3'd3, 3'd7, 3'd2,
                             3'd0, 3'd0, 3'd5, 3'd3, 3'd1, 3'd5, 3'd6, 3'd1, 3'd4};
  logic [31:0] vimm [NV] = '{32'hFFFFFFFF, 32'h00000800, 32'h00000002, 32'h12345000,
                             32'h12345001, 32'h00000800, 32'h00000003, 32'h00000000,
                             32'hFFFFFFFC, 32'h00000000, 32'h00000001, 32'hFFFFFFFE,
                             32'hFFFFF000, 32'h00000800, 32'h00100000, 32'h00000005,
                             32'h000007FF, 32'hFFFFF000};
  logic [31:0] vbase[NV] = '{32'h00000013, 32'h00000063, 32'h0000006F, 32'h00000037,
                             32'h00000037, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF,
                             32'h00112023, 32'h00B50533, 32'h00B50533, 32'h0000006F,
                             32'h00000063, 32'h00000013, 32'h0000006F, 32'h12345678,
                             32'h00000093, 32'h000000B7};
  logic [31:0] vinst[NV] = '{32'hFFF00013, 32'h000000E3, 32'h0020006F, 32'h12345037,
                             32'h00000037, 32'h01FFF07F, 32'h01FFF07F, 32'hDEADBEEF,
                             32'hFE112E23, 32'h00B50533, 32'h00B50533, 32'hFFFFF06F,
                             32'h80000063, 32'h00000013, 32'h0000006F, 32'h12345678,
                             32'h7FF00093, 32'hFFFFF0B7};
  logic        verr [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'h000};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int sat(input int n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected normal completion", name);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Caller is at a negedge; returns at the negedge after the transfer.
  task automatic send(input int k);
    logic fire;
    int   n;
    exp_t e;
    in_valid = 1'b1;
    in_type  = vt[k];
    in_imm   = vimm[k];
    in_base  = vbase[k];
    n = 0;
    fire = 1'b0;
    while (!fire && n < 200) begin
      #4;
      fire = in_ready;
      @(posedge clk);
      if (!fire) @(negedge clk);
      n++;
    end
    if (!fire) fail("send_timeout");
    else begin
      e.t = vt[k]; e.imm = vimm[k]; e.inst = vinst[k]; e.err = verr[k];
      sb.push_back(e);
      n_acc++;
      if (verr[k]) n_err++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("drain_timeout");
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold under stall.
  initial begin
    logic        held = 1'b0;
    logic [31:0] h_inst = '0;
    logic        h_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_inst", out_inst, h_inst);
          check("stall_err", 32'(out_err), 32'(h_err));
        end
        held = out_valid & !out_ready;
        h_inst = out_inst;
        h_err = out_err;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail("unexpected_word");
          else begin
            e = sb.pop_front();
            check("out_inst", out_inst, e.inst);
            check("out_err", 32'(out_err), 32'(e.err));
            if (!e.err) check("decode_back", decode(out_inst, e.t), e.imm);
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    int  pops0;
    bit  seen;
    bp_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    #1 check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1 check("in_ready_after_edge", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed words, one at a time, with latency checked
    for (int k = 0; k < NV; k++) begin
      if (k >= 8 && k < 16) continue;
      send(k);
      check("latency_s1", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("latency_s2", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    drain();
    check("acc_directed", 32'(acc_cnt), 32'(sat(n_acc)));
    check("err_directed", 32'(err_cnt), 32'(sat(n_err)));

    // Reset with two words in flight
    bp_mode = 2;
    @(posedge clk); @(negedge clk);
    send(0);
    send(1);
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_acc_cnt", 32'(acc_cnt), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    n_acc = 0;
    n_err = 0;
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_word", 32'(seen), 32'd0);

    // Stream of 8 under random backpressure
    pops0 = n_pop;
    bp_mode = 1;
    for (int k = 8; k < 16; k++) send(k);
    drain();
    bp_mode = 0;
    check("stream_pops", 32'(n_pop - pops0), 32'd8);
    check("stream_acc", 32'(acc_cnt), 32'd8);
    check("stream_err", 32'(err_cnt), 32'(sat(n_err)));

    // Push both counters past all-ones
    for (int i = 0; i < 12; i++) send(15);
    drain();
    check("sat_acc", 32'(acc_cnt), 32'(sat(n_acc)));
    check("sat_err", 32'(err_cnt), 32'(sat(n_err)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
